// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer: control FSM for an iterative AES datapath and its
// round-key expander. It holds no data. It steps through the FIPS-197 order
// one datapath operation per cycle and handshakes for each round key.
// The optional inverse cipher is built only when the macro AES_DEC_EN is
// defined. Without it, decrypt=1 at start is rejected with an err pulse.
module aes_round_sequencer #(
  parameter int KEY_TIMEOUT = 255,  // 0 disables the key_ack timeout
  parameter int TW          = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] key_len,
  input  logic       decrypt,
  input  logic       abort,
  input  logic       key_ack,
  output logic       key_req,
  output logic [3:0] key_round,
  output logic       op_valid,
  output logic [2:0] op_sel,
  output logic [3:0] round,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_KEY    = 4'd1;
  localparam logic [3:0] S_ARK    = 4'd2;
  localparam logic [3:0] S_SUB    = 4'd3;
  localparam logic [3:0] S_SHIFT  = 4'd4;
  localparam logic [3:0] S_MIX    = 4'd5;
  localparam logic [3:0] S_DONE   = 4'd6;
`ifdef AES_DEC_EN
  localparam logic [3:0] S_ISUB   = 4'd7;
  localparam logic [3:0] S_ISHIFT = 4'd8;
  localparam logic [3:0] S_IMIX   = 4'd9;
`endif

  localparam logic [2:0] OP_NOP    = 3'd0;
  localparam logic [2:0] OP_ARK    = 3'd1;
  localparam logic [2:0] OP_SUB    = 3'd2;
  localparam logic [2:0] OP_SHIFT  = 3'd3;
  localparam logic [2:0] OP_MIX    = 3'd4;
`ifdef AES_DEC_EN
  localparam logic [2:0] OP_ISUB   = 3'd5;
  localparam logic [2:0] OP_ISHIFT = 3'd6;
  localparam logic [2:0] OP_IMIX   = 3'd7;
`endif

  // Last counter value before the timeout fires (only used if KEY_TIMEOUT!=0)
  localparam logic [TW-1:0] TO_LAST = TW'(KEY_TIMEOUT - 1);

  logic [3:0]    state_q, state_d;
  logic [3:0]    round_q, round_d;
  logic [3:0]    nr_q, nr_d;
  logic [TW-1:0] tmo_q, tmo_d;
`ifdef AES_DEC_EN
  logic          dec_q, dec_d;
`endif
  logic          key_req_q, key_req_d;
  logic [3:0]    key_round_q, key_round_d;
  logic          op_valid_q, op_valid_d;
  logic [2:0]    op_sel_q, op_sel_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic          legal_start;
  logic [3:0]    nr_sel;

  // Decode the requested key size and decide whether a start is acceptable
  always_comb begin
    case (key_len)
      2'd0:    nr_sel = 4'd10;
      2'd1:    nr_sel = 4'd12;
      default: nr_sel = 4'd14;
    endcase
`ifdef AES_DEC_EN
    legal_start = (key_len != 2'd3);
`else
    legal_start = (key_len != 2'd3) && !decrypt;
`endif
  end

  // Next-state, round counter and key-wait timeout
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    nr_d    = nr_q;
    tmo_d   = tmo_q;
    err_d   = 1'b0;
`ifdef AES_DEC_EN
    dec_d   = dec_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          if (legal_start) begin
            nr_d    = nr_sel;
            round_d = 4'd0;
`ifdef AES_DEC_EN
            dec_d   = decrypt;
            if (decrypt) round_d = nr_sel;
`endif
            state_d = S_KEY;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_KEY: begin
        if (key_ack) begin
          state_d = S_ARK;
        end else if (KEY_TIMEOUT != 0 && tmo_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_ARK: begin
`ifdef AES_DEC_EN
        if (dec_q) begin
          // Initial whitening goes straight into the first inverse round;
          // later rounds pass through INV_MIX, which steps the round down.
          if (round_q == 4'd0) begin
            state_d = S_DONE;
          end else if (round_q == nr_q) begin
            round_d = round_q - 4'd1;
            state_d = S_ISHIFT;
          end else begin
            state_d = S_IMIX;
          end
        end else
`endif
        if (round_q == nr_q) begin
          state_d = S_DONE;
        end else begin
          round_d = round_q + 4'd1;
          state_d = S_SUB;
        end
      end
      S_SUB:   state_d = S_SHIFT;
      // The final round skips MixColumns
      S_SHIFT: state_d = (round_q == nr_q) ? S_KEY : S_MIX;
      S_MIX:   state_d = S_KEY;
`ifdef AES_DEC_EN
      S_ISHIFT: state_d = S_ISUB;
      S_ISUB:   state_d = S_KEY;
      S_IMIX: begin
        round_d = round_q - 4'd1;
        state_d = S_ISHIFT;
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // abort overrides everything once an operation is running
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      err_d   = 1'b0;
    end
    if (state_d == S_IDLE) round_d = 4'd0;
    if (state_d == S_KEY && state_q != S_KEY) tmo_d = '0;
  end

  // Outputs are registered, decoded from the state being entered
  always_comb begin
    key_req_d   = (state_d == S_KEY);
    key_round_d = (state_d == S_KEY) ? round_d : 4'd0;
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    op_valid_d  = 1'b1;
    case (state_d)
      S_ARK:    op_sel_d = OP_ARK;
      S_SUB:    op_sel_d = OP_SUB;
      S_SHIFT:  op_sel_d = OP_SHIFT;
      S_MIX:    op_sel_d = OP_MIX;
`ifdef AES_DEC_EN
      S_ISUB:   op_sel_d = OP_ISUB;
      S_ISHIFT: op_sel_d = OP_ISHIFT;
      S_IMIX:   op_sel_d = OP_IMIX;
`endif
      default: begin
        op_sel_d   = OP_NOP;
        op_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      round_q     <= 4'd0;
      nr_q        <= 4'd0;
      tmo_q       <= '0;
`ifdef AES_DEC_EN
      dec_q       <= 1'b0;
`endif
      key_req_q   <= 1'b0;
      key_round_q <= 4'd0;
      op_valid_q  <= 1'b0;
      op_sel_q    <= 3'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      round_q     <= round_d;
      nr_q        <= nr_d;
      tmo_q       <= tmo_d;
`ifdef AES_DEC_EN
      dec_q       <= dec_d;
`endif
      key_req_q   <= key_req_d;
      key_round_q <= key_round_d;
      op_valid_q  <= op_valid_d;
      op_sel_q    <= op_sel_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign key_req   = key_req_q;
  assign key_round = key_round_q;
  assign op_valid  = op_valid_q;
  assign op_sel    = op_sel_q;
  assign round     = round_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed bench for aes_round_sequencer: a table of whole-operation
// scenarios (key size, direction, ack delay, injected start/abort/reset)
// with hand-computed cycle numbers, plus a few short idle-state sequences.
module tb_aes_round_sequencer;

  logic       clk = 1'b0;
  logic       reset, start, decrypt, abort, key_ack;
  logic [1:0] key_len;
  logic       key_req, op_valid, busy, done, err;
  logic [3:0] key_round, round;
  logic [2:0] op_sel;

  always #5 clk = ~clk;

  aes_round_sequencer #(.KEY_TIMEOUT(4), .TW(8)) dut (
    .clk(clk), .reset(reset), .start(start), .key_len(key_len),
    .decrypt(decrypt), .abort(abort), .key_ack(key_ack),
    .key_req(key_req), .key_round(key_round), .op_valid(op_valid),
    .op_sel(op_sel), .round(round), .busy(busy), .done(done), .err(err)
  );

  // Cycle numbers count from 1 = first cycle after the start-accept edge; 0 = never
  typedef struct {
    logic [1:0] kl;
    logic       dec;
    int         dly;        // ack asserted in cycle dly+1 of each request
    int         inj_start;
    int         abort_at;
    int         reset_at;
    int         e_done;
    int         e_err;
    int         e_idle;
    int         e_nops;
    int         e_nreq;
    int         e_hold;
    int         e_busy;
  } vec_t;

  vec_t tv[11];
  int   pass_cnt = 0;
  int   chk_cnt  = 0;
  int   exp_ops[$];

  task automatic chk(input string name, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Operation order straight from the cipher definition
  function automatic void build_trace(input int nr, input bit dec);
    exp_ops.delete();
    exp_ops.push_back(1);
    for (int r = 1; r < nr; r++) begin
      if (dec) begin
        exp_ops.push_back(6); exp_ops.push_back(5);
        exp_ops.push_back(1); exp_ops.push_back(7);
      end else begin
        exp_ops.push_back(2); exp_ops.push_back(3);
        exp_ops.push_back(4); exp_ops.push_back(1);
      end
    end
    if (dec) begin exp_ops.push_back(6); exp_ops.push_back(5); end
    else     begin exp_ops.push_back(2); exp_ops.push_back(3); end
    exp_ops.push_back(1);
  endfunction

  task automatic run_vec(input int idx, input vec_t v);
    int ops[$], krs[$], holds[$];
    int k, hold, done_c, err_c, idle_c, done_n, busy_s, rnd_done, bad, nr;
    string tag;
    tag = $sformatf("v%0d", idx);
    nr  = (v.kl == 2'd0) ? 10 : (v.kl == 2'd1) ? 12 : 14;
    hold = 0; done_c = 0; err_c = 0; idle_c = 0; done_n = 0; busy_s = 0; rnd_done = 0;
    key_len = v.kl; decrypt = v.dec; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 1;
    while (idle_c == 0 && k <= 300) begin
      if (op_valid) ops.push_back(int'(op_sel));
      if (key_req) begin
        if (hold == 0) krs.push_back(int'(key_round));
        hold++;
      end else if (hold != 0) begin
        holds.push_back(hold);
        hold = 0;
      end
      if (done) begin done_n++; done_c = k; rnd_done = int'(round); end
      if (err) err_c = k;
      if (busy) busy_s = 1;
      if (!busy) begin
        idle_c = k;
        chk({tag, " idle outputs"},
            int'({key_req, op_valid, op_sel, round, key_round, done}), 0);
      end
      key_ack = key_req && (hold == v.dly + 1);
      start   = (k == v.inj_start);
      abort   = (k == v.abort_at);
      reset   = (k == v.reset_at);
      if (idle_c == 0) begin
        @(posedge clk); #1;
        k++;
      end
    end
    key_ack = 1'b0; start = 1'b0; abort = 1'b0; reset = 1'b0;
    chk({tag, " run bound"}, int'(idle_c != 0), 1);
    chk({tag, " done cycle"}, done_c, v.e_done);
    chk({tag, " done pulses"}, done_n, int'(v.e_done != 0));
    chk({tag, " err cycle"}, err_c, v.e_err);
    chk({tag, " idle cycle"}, idle_c, v.e_idle);
    chk({tag, " busy seen"}, busy_s, v.e_busy);
    if (v.e_done != 0) chk({tag, " round at done"}, rnd_done, v.dec ? 0 : nr);
    build_trace(nr, v.dec);
    bad = (ops.size() == v.e_nops) ? 0 : 1000;
    foreach (ops[j]) if (j < exp_ops.size() && ops[j] != exp_ops[j]) bad++;
    chk({tag, " op trace errors"}, bad, 0);
    bad = (krs.size() == v.e_nreq) ? 0 : 1000;
    foreach (krs[j]) if (krs[j] != (v.dec ? nr - j : j)) bad++;
    chk({tag, " key_round errors"}, bad, 0);
    if (v.e_hold != 0) begin
      bad = (holds.size() == v.e_nreq) ? 0 : 1000;
      foreach (holds[j]) if (holds[j] != v.e_hold) bad++;
      chk({tag, " key_req hold errors"}, bad, 0);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; key_len = 2'd0; decrypt = 1'b0;
    abort = 1'b0; key_ack = 1'b0;

    //         kl    dec  dly inj ab  rst done err idle nops nreq hold busy
    tv[0]  = '{2'd0, 1'b0, 0,   0,  0,  0,  52, 0,  53,  40,  11,  1,  1};
    tv[1]  = '{2'd2, 1'b0, 3,   0,  0,  0, 117, 0, 118,  56,  15,  4,  1};
    tv[2]  = '{2'd3, 1'b0, 0,   0,  0,  0,   0, 1,   1,   0,   0,  0,  0};
    tv[3]  = '{2'd0, 1'b0, 0,  23,  0,  0,  52, 0,  53,  40,  11,  1,  1};
    tv[4]  = '{2'd0, 1'b0, 0,   0, 19,  0,   0, 0,  20,  15,   4,  1,  1};
    tv[5]  = '{2'd0, 1'b0, 1,   0,  0,  0,  63, 0,  64,  40,  11,  2,  1};
    tv[6]  = '{2'd0, 1'b0, 255, 0,  0,  0,   0, 5,   5,   0,   1,  4,  1};
    tv[7]  = '{2'd1, 1'b0, 0,   0,  0, 33,   0, 0,  34,  26,   7,  1,  1};
    tv[8]  = '{2'd0, 1'b0, 0,   0, 52,  0,  52, 0,  53,  40,  11,  1,  1};
    tv[9]  = '{2'd1, 1'b0, 0,   0,  0,  0,  62, 0,  63,  48,  13,  1,  1};
`ifdef AES_DEC_EN
    tv[10] = '{2'd1, 1'b1, 0,   0,  0,  0,  62, 0,  63,  48,  13,  1,  1};
`else
    tv[10] = '{2'd1, 1'b1, 0,   0,  0,  0,   0, 1,   1,   0,   0,  0,  0};
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("reset outputs",
        int'({key_req, key_round, op_valid, op_sel, round, busy, done, err}), 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // start and abort together in IDLE: nothing happens
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    chk("start+abort busy", int'(busy), 0);
    chk("start+abort err", int'(err), 0);

    // key_ack with no request outstanding is ignored
    key_ack = 1'b1;
    @(posedge clk); #1;
    key_ack = 1'b0;
    chk("stray ack busy", int'(busy), 0);
    chk("stray ack op_valid", int'(op_valid), 0);
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) run_vec(i, tv[i]);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
